// File: rtl/mc_top.sv
// Two-pass-per-day sample averager: a pricing pass (P1) forms a bound C, a decision pass (P2)
// streams max(p, C) per sample and folds the day's average back into V for the next day.
module mc_top #(
  parameter int DATA_LEN = 256,
  parameter int DAYS     = 8,
  parameter int W        = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   state,
  input  logic [W-1:0] in,
  output logic         valid,
  output logic [W-1:0] out,
  output logic         resend
);

  localparam int CW   = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam int DAYW = (DAYS > 1) ? $clog2(DAYS) : 1;
  localparam int SW   = W + CW;

  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_RUN   = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  typedef enum logic [2:0] {IDLE, P1, CALC, P2, DONE, FIN} fsm_e;

  fsm_e            st_q, st_d;
  logic [W-1:0]    k_q, k_d, w_q, w_d, q_q, q_d, s_q, s_d;
  logic [W-1:0]    v_q, v_d, m_q, m_d, c_q, c_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DAYW-1:0] day_q, day_d;
  logic            valid_q, valid_d;
  logic [W-1:0]    out_q, out_d;

  logic [W-1:0]    p_val, o_val, c_sat;
  logic [SW-1:0]   p_sum, o_sum;
  logic [2*W:0]    mix, scaled;
  logic            last_sample, more_days;

  assign p_val       = (k_q > in) ? (k_q - in) : '0;
  assign o_val       = (p_val > c_q) ? p_val : c_q;
  assign p_sum       = sum_q + SW'(p_val);
  assign o_sum       = sum_q + SW'(o_val);
  assign last_sample = (cnt_q == CW'(DATA_LEN - 1));
  assign more_days   = (day_q < DAYW'(DAYS - 1));

  // Q1.11 blend of this day's mean payoff and carried value; anything above 1.11 format saturates.
  assign mix    = (2*W+1)'(m_q) * (2*W+1)'(w_q) + (2*W+1)'(v_q) * (2*W+1)'(q_q);
  assign scaled = mix >> (W - 1);
  assign c_sat  = (|scaled[2*W:W]) ? '1 : scaled[W-1:0];

  assign resend = (st_q == CALC) || ((st_q == DONE) && more_days);
  assign valid  = valid_q;
  assign out    = out_q;

  always_comb begin
    st_d    = st_q;
    k_d     = k_q;
    w_d     = w_q;
    q_d     = q_q;
    s_d     = s_q;
    v_d     = v_q;
    m_d     = m_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    day_d   = day_q;
    valid_d = 1'b0;
    out_d   = out_q;
    ptr_d   = (state == CMD_LOAD) ? ptr_q : 2'd0;

    unique case (st_q)
      IDLE: begin
        if (state == CMD_RUN) begin
          st_d  = P1;
          v_d   = s_q;
          day_d = '0;
          cnt_d = '0;
          sum_d = '0;
        end else if (state == CMD_LOAD) begin
          unique case (ptr_q)
            2'd0: k_d = in;
            2'd1: w_d = in;
            2'd2: q_d = in;
            default: s_d = in;
          endcase
          ptr_d = ptr_q + 2'd1;
        end
      end
      P1: begin
        if (state == CMD_RUN) begin
          sum_d = p_sum;
          cnt_d = cnt_q + 1'b1;
          if (last_sample) begin
            m_d   = W'(p_sum >> CW);
            cnt_d = '0;
            st_d  = CALC;
          end
        end
      end
      CALC: begin
        c_d   = c_sat;
        sum_d = '0;
        cnt_d = '0;
        st_d  = P2;
      end
      P2: begin
        if (state == CMD_RUN) begin
          out_d   = o_val;
          valid_d = 1'b1;
          sum_d   = o_sum;
          cnt_d   = cnt_q + 1'b1;
          if (last_sample) begin
            cnt_d = '0;
            st_d  = DONE;
          end
        end
      end
      DONE: begin
        v_d = W'(sum_q >> CW);
        if (more_days) begin
          day_d = day_q + 1'b1;
          sum_d = '0;
          cnt_d = '0;
          st_d  = P1;
        end else begin
          // The final value is presented during FIN straight from the output register.
          out_d   = W'(sum_q >> CW);
          valid_d = 1'b1;
          st_d    = FIN;
        end
      end
      default: st_d = IDLE;
    endcase

    if (state == CMD_ABORT) begin
      st_d    = IDLE;
      cnt_d   = '0;
      sum_d   = '0;
      day_d   = '0;
      valid_d = 1'b0;
      out_d   = out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      k_q     <= '0;
      w_q     <= '0;
      q_q     <= '0;
      s_q     <= '0;
      v_q     <= '0;
      m_q     <= '0;
      c_q     <= '0;
      ptr_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      day_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      st_q    <= st_d;
      k_q     <= k_d;
      w_q     <= w_d;
      q_q     <= q_d;
      s_q     <= s_d;
      v_q     <= v_d;
      m_q     <= m_d;
      c_q     <= c_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      day_q   <= day_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_mc_top.sv
// Randomized bench for mc_top: a per-day arithmetic model (means, blend, max) predicts every
// output value, resend pulse and the final run value.
module tb_mc_top;

  localparam int DL = 256;
  localparam int ND = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  state_s = 2'b00;
  logic [11:0] in_s = 12'h000;
  logic        valid_w;
  logic [11:0] out_w;
  logic        resend_w;

  int checks = 0;
  int failures = 0;
  int rs_count = 0;
  int pk = 0, pw = 0, pq = 0, ps = 0;
  int last_out = 0;
  logic [11:0] obs_day [ND];

  mc_top #(.DATA_LEN(DL), .DAYS(ND), .W(12)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .state  (state_s),
    .in     (in_s),
    .valid  (valid_w),
    .out    (out_w),
    .resend (resend_w)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (resend_w) rs_count++;
  endtask

  function automatic int gen(input int mode);
    int hi;
    case (mode)
      0: return 0;
      1: return 'h400;
      2: return int'($urandom_range(0, 4095));
      default: begin
        hi = pk + 300;
        if (hi > 4095) hi = 4095;
        return int'($urandom_range(0, hi));
      end
    endcase
  endfunction

  function automatic int pval(input int x);
    return (pk > x) ? (pk - x) : 0;
  endfunction

  task automatic load(input int k, input int w, input int q, input int s);
    state_s = 2'b01;
    in_s = 12'(k); tick();
    in_s = 12'(w); tick();
    in_s = 12'(q); tick();
    in_s = 12'(s); tick();
    state_s = 2'b00;
    in_s = 12'h000;
    tick();
    pk = k; pw = w; pq = q; ps = s;
    checks++;
    if (valid_w !== 1'b0 || resend_w !== 1'b0) begin
      failures++;
      $display("FAIL load_quiet: valid=%0b resend=%0b required 0/0", valid_w, resend_w);
    end
  endtask

  // Drives ndays days of samples from IDLE and checks every observable cycle against the model.
  task automatic run_days(input int ndays, input int mode, input int pause_en,
                          input int abort_p1, input int rst_at);
    int vm, x, p, o, sum, m, c, n_out, npause;
    logic exp_rs;
    vm = ps;
    state_s = 2'b10;
    in_s = 12'($urandom);
    tick();
    checks++;
    if (valid_w !== 1'b0 || resend_w !== 1'b0) begin
      failures++;
      $display("FAIL kick: valid=%0b resend=%0b required 0/0", valid_w, resend_w);
    end
    for (int d = 0; d < ndays; d++) begin
      sum = 0;
      for (int i = 0; i < DL; i++) begin
        npause = (pause_en == 1 && $urandom_range(0, 15) == 0) ? 1 :
                 (pause_en == 2 && i == 50) ? 5 : 0;
        for (int k = 0; k < npause; k++) begin
          state_s = 2'b00;
          in_s = 12'($urandom);
          tick();
          checks++;
          if (valid_w !== 1'b0 || resend_w !== 1'b0) begin
            failures++;
            $display("FAIL p1_pause: day=%0d i=%0d valid=%0b resend=%0b required 0/0", d, i, valid_w, resend_w);
          end
        end
        if (d == 0 && i == abort_p1) begin
          state_s = 2'b11;
          tick();
          checks++;
          if (valid_w !== 1'b0 || resend_w !== 1'b0) begin
            failures++;
            $display("FAIL abort_p1: valid=%0b resend=%0b required 0/0", valid_w, resend_w);
          end
          state_s = 2'b00;
          repeat (3) begin
            tick();
            checks++;
            if (valid_w !== 1'b0 || resend_w !== 1'b0) begin
              failures++;
              $display("FAIL abort_idle: valid=%0b resend=%0b required 0/0", valid_w, resend_w);
            end
          end
          return;
        end
        state_s = 2'b10;
        x = gen(mode);
        in_s = 12'(x);
        sum += pval(x);
        tick();
        if (i < DL - 1) begin
          checks++;
          if (valid_w !== 1'b0 || resend_w !== 1'b0) begin
            failures++;
            $display("FAIL p1_sample: day=%0d i=%0d valid=%0b resend=%0b required 0/0", d, i, valid_w, resend_w);
          end
        end
      end
      m = sum >> 8;
      c = (m * pw + vm * pq) >> 11;
      if (c > 4095) c = 4095;
      checks++;
      if (resend_w !== 1'b1) begin
        failures++;
        $display("FAIL calc_resend: day=%0d resend=%0b required 1", d, resend_w);
      end
      in_s = 12'($urandom);
      tick();
      checks++;
      if (resend_w !== 1'b0) begin
        failures++;
        $display("FAIL calc_width: day=%0d resend=%0b required 0", d, resend_w);
      end
      sum = 0;
      n_out = 0;
      for (int i = 0; i < DL; i++) begin
        npause = (pause_en == 1 && $urandom_range(0, 15) == 0) ? 1 :
                 (pause_en == 2 && i == 50) ? 5 : 0;
        for (int k = 0; k < npause; k++) begin
          state_s = 2'b00;
          in_s = 12'($urandom);
          tick();
          if (valid_w) n_out++;
          checks++;
          if (valid_w !== 1'b0 || out_w !== 12'(last_out)) begin
            failures++;
            $display("FAIL p2_pause: day=%0d i=%0d valid=%0b out=%03h required 0/%03h", d, i, valid_w, out_w, 12'(last_out));
          end
        end
        state_s = 2'b10;
        x = gen(mode);
        p = pval(x);
        o = (p > c) ? p : c;
        sum += o;
        in_s = 12'(x);
        tick();
        if (valid_w) n_out++;
        last_out = o;
        if (i == 0) obs_day[d] = out_w;
        checks++;
        if (valid_w !== 1'b1 || out_w !== 12'(o) || (i < DL - 1 && resend_w !== 1'b0)) begin
          failures++;
          $display("FAIL p2_out: day=%0d i=%0d valid=%0b out=%03h resend=%0b required 1/%03h/0", d, i, valid_w, out_w, resend_w, 12'(o));
        end
        if (d == 0 && i == rst_at) begin
          #2 rst_n = 1'b0;
          #1;
          checks++;
          if (out_w !== 12'h000 || valid_w !== 1'b0 || resend_w !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: out=%03h valid=%0b resend=%0b required 000/0/0", out_w, valid_w, resend_w);
          end
          last_out = 0;
          state_s = 2'b00;
          return;
        end
      end
      checks++;
      if (n_out !== DL) begin
        failures++;
        $display("FAIL p2_count: day=%0d outputs=%0d required %0d", d, n_out, DL);
      end
      vm = sum >> 8;
      exp_rs = (d < ND - 1);
      checks++;
      if (resend_w !== exp_rs) begin
        failures++;
        $display("FAIL done_resend: day=%0d resend=%0b required %0b", d, resend_w, exp_rs);
      end
      if (d == ndays - 1 && ndays < ND) begin
        state_s = 2'b11;
        tick();
        checks++;
        if (valid_w !== 1'b0 || resend_w !== 1'b0) begin
          failures++;
          $display("FAIL abort_done: valid=%0b resend=%0b required 0/0", valid_w, resend_w);
        end
        state_s = 2'b00;
        return;
      end
      in_s = 12'($urandom);
      tick();
    end
    checks++;
    if (valid_w !== 1'b1 || out_w !== 12'(vm) || resend_w !== 1'b0) begin
      failures++;
      $display("FAIL fin: valid=%0b out=%03h resend=%0b required 1/%03h/0", valid_w, out_w, resend_w, 12'(vm));
    end
    last_out = vm;
    state_s = 2'b00;
    tick();
    checks++;
    if (valid_w !== 1'b0 || out_w !== 12'(vm) || resend_w !== 1'b0) begin
      failures++;
      $display("FAIL fin_width: valid=%0b out=%03h resend=%0b required 0/%03h/0", valid_w, out_w, resend_w, 12'(vm));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    state_s = 2'b00;
    #12;
    checks++;
    if (out_w !== 12'h000 || valid_w !== 1'b0 || resend_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: out=%03h valid=%0b resend=%0b required 000/0/0", out_w, valid_w, resend_w);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    last_out = 0;
    pk = 0; pw = 0; pq = 0; ps = 0;
  endtask

  task automatic test_spec_day0();
    load('h300, 'h555, 'h5B1, 'h1EB);
    rs_count = 0;
    run_days(1, 0, 0, -1, -1);
    checks++;
    if (obs_day[0] !== 12'h35D) begin
      failures++;
      $display("FAIL spec_day0_c: out=%03h required 35d", obs_day[0]);
    end
    checks++;
    if (rs_count !== 2) begin
      failures++;
      $display("FAIL spec_day0_resends: pulses=%0d required 2", rs_count);
    end
  endtask

  task automatic test_high_input();
    run_days(1, 1, 0, -1, -1);
    checks++;
    if (obs_day[0] !== 12'h15D) begin
      failures++;
      $display("FAIL high_input_c: out=%03h required 15d", obs_day[0]);
    end
  endtask

  task automatic test_saturate();
    load('h300, 'hFFF, 'hFFF, 'hFFF);
    run_days(1, 0, 0, -1, -1);
    checks++;
    if (obs_day[0] !== 12'hFFF) begin
      failures++;
      $display("FAIL saturate: out=%03h required fff", obs_day[0]);
    end
  endtask

  task automatic test_full_run();
    load('h300, 'h555, 'h5B1, 'h1EB);
    rs_count = 0;
    run_days(ND, 0, 0, -1, -1);
    checks++;
    if (obs_day[1] !== 12'h464) begin
      failures++;
      $display("FAIL full_run_day1_c: out=%03h required 464", obs_day[1]);
    end
    checks++;
    if (rs_count !== 15) begin
      failures++;
      $display("FAIL full_run_resends: pulses=%0d required 15", rs_count);
    end
  endtask

  task automatic test_abort_and_pause();
    load(int'($urandom_range(0, 4095)), int'($urandom_range(0, 2047)),
         int'($urandom_range(0, 2047)), int'($urandom_range(0, 4095)));
    rs_count = 0;
    run_days(1, 2, 0, 100, -1);
    checks++;
    if (rs_count !== 0) begin
      failures++;
      $display("FAIL abort_no_resend: pulses=%0d required 0", rs_count);
    end
    run_days(1, 3, 2, -1, -1);
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 3; r++) begin
      load(int'($urandom_range(0, 4095)), int'($urandom_range(0, 2047)),
           int'($urandom_range(0, 2047)), int'($urandom_range(0, 4095)));
      run_days(ND, 3, 1, -1, -1);
    end
  endtask

  task automatic test_reset_mid_p2();
    load('h300, 'h555, 'h5B1, 'h1EB);
    run_days(1, 0, 0, -1, 100);
    tick();
    tick();
    rst_n = 1'b1;
    pk = 0; pw = 0; pq = 0; ps = 0;
    repeat (3) begin
      tick();
      checks++;
      if (valid_w !== 1'b0 || resend_w !== 1'b0 || out_w !== 12'h000) begin
        failures++;
        $display("FAIL reset_idle: valid=%0b resend=%0b out=%03h required 0/0/000", valid_w, resend_w, out_w);
      end
    end
    run_days(1, 2, 0, -1, -1);
    load('h300, 'h555, 'h5B1, 'h1EB);
    run_days(1, 0, 0, -1, -1);
    checks++;
    if (obs_day[0] !== 12'h35D) begin
      failures++;
      $display("FAIL reset_rerun_c: out=%03h required 35d", obs_day[0]);
    end
  endtask

  initial begin
    test_reset();
    test_spec_day0();
    test_high_input();
    test_saturate();
    test_full_run();
    test_abort_and_pause();
    test_random_runs();
    test_reset_mid_p2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
